// File: rtl/game_ctrl.sv
// game_ctrl: START/PLAY/WIN/END flow plus once-per-frame ball kinematics for the brick renderer.
// Ball coordinates are the ball centre; geometry compares run 11 bits wide so nothing wraps near 0.
module game_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int BALL_R   = 8,
  parameter int SPEED_X  = 2,
  parameter int SPEED_Y  = 2,
  parameter int PADDLE_Y = 440,
  parameter int PADDLE_W = 80,
  parameter int START_X  = 320,
  parameter int START_Y  = 400
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        frame_tick,
  input  logic        key_start,
  input  logic [9:0]  paddle_x,
  input  logic [49:0] brick_collision,
  input  logic        win_sig,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [1:0]  game_state,
  output logic        game_reset
);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_WIN   = 2'b10,
    ST_END   = 2'b11
  } state_t;

  localparam logic [10:0] BR     = 11'(BALL_R);
  localparam logic [10:0] SX     = 11'(SPEED_X);
  localparam logic [10:0] SY     = 11'(SPEED_Y);
  localparam logic [10:0] XMAX   = 11'(SCREEN_W - 1 - BALL_R);
  localparam logic [10:0] YLIM   = 11'(SCREEN_H);
  localparam logic [10:0] PY     = 11'(PADDLE_Y);
  localparam logic [10:0] PHW    = 11'(PADDLE_W / 2);
  localparam logic [9:0]  X0     = 10'(START_X);
  localparam logic [9:0]  Y0     = 10'(START_Y);
  localparam logic [9:0]  BR10   = 10'(BALL_R);
  localparam logic [9:0]  XMAX10 = 10'(SCREEN_W - 1 - BALL_R);
  localparam logic [9:0]  YPAD10 = 10'(PADDLE_Y - BALL_R);

  state_t      state, state_nxt;
  logic        key_start_d;
  logic        key_rise;
  logic        any_hit;
  logic        dir_x, dir_y;
  logic        dir_y_eff;
  logic        hit_latch;
  logic [10:0] bx, by, px;
  logic [9:0]  step_x, step_y;
  logic        step_dx, step_dy;
  logic        miss;
  logic [9:0]  ball_x_nxt, ball_y_nxt;
  logic        dir_x_nxt, dir_y_nxt;
  logic        hit_nxt;
  logic        game_reset_nxt;

  // dir_x: 1 = right, 0 = left; dir_y: 1 = down, 0 = up
  assign bx         = {1'b0, ball_x};
  assign by         = {1'b0, ball_y};
  assign px         = {1'b0, paddle_x};
  assign key_rise   = key_start & ~key_start_d;
  assign any_hit    = |brick_collision;
  assign dir_y_eff  = dir_y ^ hit_latch;
  assign game_state = state;

  always_comb begin
    step_x  = ball_x;
    step_dx = dir_x;
    if (!dir_x) begin
      if (bx < BR + SX) begin
        step_x  = BR10;
        step_dx = 1'b1;
      end else begin
        step_x = 10'(bx - SX);
      end
    end else begin
      if (bx + SX > XMAX) begin
        step_x  = XMAX10;
        step_dx = 1'b0;
      end else begin
        step_x = 10'(bx + SX);
      end
    end
  end

  // A pending brick hit flips vertical direction before the wall/paddle rules apply
  always_comb begin
    step_y  = ball_y;
    step_dy = dir_y_eff;
    miss    = 1'b0;
    if (!dir_y_eff) begin
      if (by < BR + SY) begin
        step_y  = BR10;
        step_dy = 1'b1;
      end else begin
        step_y = 10'(by - SY);
      end
    end else if ((by + BR <= PY) && (by + BR + SY >= PY) &&
                 (bx + PHW >= px) && (bx <= px + PHW)) begin
      step_y  = YPAD10;
      step_dy = 1'b0;
    end else if (by + BR + SY >= YLIM) begin
      miss = 1'b1;
    end else begin
      step_y = 10'(by + SY);
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_START;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_START: if (key_rise) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (win_sig)                 state_nxt = ST_WIN;
        else if (frame_tick && miss) state_nxt = ST_END;
      end
      ST_WIN, ST_END: if (key_rise) state_nxt = ST_START;
      default: state_nxt = ST_START;
    endcase
  end

  // The latch is refilled from the tick cycle's own collision flags so no pulse is dropped
  always_comb begin
    ball_x_nxt     = ball_x;
    ball_y_nxt     = ball_y;
    dir_x_nxt      = dir_x;
    dir_y_nxt      = dir_y;
    hit_nxt        = hit_latch;
    game_reset_nxt = 1'b0;
    case (state)
      ST_START: begin
        ball_x_nxt     = X0;
        ball_y_nxt     = Y0;
        dir_x_nxt      = 1'b1;
        dir_y_nxt      = 1'b0;
        hit_nxt        = 1'b0;
        game_reset_nxt = key_rise;
      end
      ST_PLAY: begin
        if (frame_tick) begin
          ball_x_nxt = step_x;
          ball_y_nxt = step_y;
          dir_x_nxt  = step_dx;
          dir_y_nxt  = step_dy;
          hit_nxt    = any_hit;
        end else begin
          hit_nxt = hit_latch | any_hit;
        end
      end
      default: begin
        if (key_rise) begin
          ball_x_nxt = X0;
          ball_y_nxt = Y0;
          dir_x_nxt  = 1'b1;
          dir_y_nxt  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_start_d <= 1'b0;
      ball_x      <= X0;
      ball_y      <= Y0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b0;
      hit_latch   <= 1'b0;
      game_reset  <= 1'b0;
    end else begin
      key_start_d <= key_start;
      ball_x      <= ball_x_nxt;
      ball_y      <= ball_y_nxt;
      dir_x       <= dir_x_nxt;
      dir_y       <= dir_y_nxt;
      hit_latch   <= hit_nxt;
      game_reset  <= game_reset_nxt;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scenario tasks plus a randomized run, all checked against an integer game model.
module tb_game_ctrl;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic        frame_tick;
  logic        key_start;
  logic [9:0]  paddle_x;
  logic [49:0] brick_collision;
  logic        win_sig;
  logic [9:0]  ball_x, ball_y;
  logic [1:0]  game_state;
  logic        game_reset;

  int checks = 0;
  int fails  = 0;

  // Model: positions in pixels, velocities as +1/-1 (vx>0 right, vy>0 down)
  int m_x, m_y, m_vx, m_vy, m_state;
  bit m_hit, m_key_d, m_rst_pulse;

  game_ctrl dut (
    .vga_clk         (vga_clk),
    .sys_rst_n       (sys_rst_n),
    .frame_tick      (frame_tick),
    .key_start       (key_start),
    .paddle_x        (paddle_x),
    .brick_collision (brick_collision),
    .win_sig         (win_sig),
    .ball_x          (ball_x),
    .ball_y          (ball_y),
    .game_state      (game_state),
    .game_reset      (game_reset)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_park();
    m_x = 320; m_y = 400; m_vx = 1; m_vy = -1;
  endtask

  task automatic model_reset();
    model_park();
    m_state = 0; m_hit = 0; m_key_d = 0; m_rst_pulse = 0;
  endtask

  task automatic model_edge(input bit fr, input bit key, input logic [49:0] coll, input bit win);
    bit rise, used_hit, miss;
    int px, ox, cx, cy;
    rise = key && !m_key_d;
    m_key_d = key;
    m_rst_pulse = 0;
    miss = 0;
    px = int'(paddle_x);
    case (m_state)
      0: begin
        model_park();
        if (rise) begin m_state = 1; m_rst_pulse = 1; m_hit = 0; end
      end
      1: begin
        used_hit = m_hit;
        if (fr) begin
          ox = m_x;
          cx = m_x + 2 * m_vx;
          if (cx < 8)        begin m_x = 8;   m_vx = 1;  end
          else if (cx > 631) begin m_x = 631; m_vx = -1; end
          else m_x = cx;
          if (used_hit) m_vy = -m_vy;
          cy = m_y + 2 * m_vy;
          if (m_vy < 0) begin
            if (cy < 8) begin m_y = 8; m_vy = 1; end
            else m_y = cy;
          end else if (m_y + 8 <= 440 && m_y + 10 >= 440 && ox + 40 >= px && ox <= px + 40) begin
            m_y = 432; m_vy = -1;
          end else if (cy + 8 >= 480) begin
            miss = 1;
          end else begin
            m_y = cy;
          end
          m_hit = (coll != 0);
        end else if (coll != 0) begin
          m_hit = 1;
        end
        if (win)       m_state = 2;
        else if (miss) m_state = 3;
      end
      default: begin
        if (rise) begin model_park(); m_state = 0; end
      end
    endcase
  endtask

  task automatic do_cycle(input bit fr, input bit key, input logic [49:0] coll, input bit win);
    frame_tick = fr; key_start = key; brick_collision = coll; win_sig = win;
    @(posedge vga_clk);
    model_edge(fr, key, coll, win);
    #1;
    frame_tick = 1'b0; brick_collision = '0; win_sig = 1'b0;
  endtask

  task automatic run_tick(input bit track);
    if (track) paddle_x = 10'(m_x);
    else       paddle_x = 10'((m_x < 320) ? m_x + 120 : m_x - 120);
    do_cycle(1, 0, '0, 0);
    do_cycle(0, 0, '0, 0);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; frame_tick = 0; key_start = 0; paddle_x = 10'd320;
    brick_collision = '0; win_sig = 0;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    checks++;
    if (game_state !== 2'b00) begin fails++; $display("[TB] FAIL reset_state got %0d expected 0", game_state); end
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd400) begin
      fails++; $display("[TB] FAIL reset_ball got (%0d,%0d) expected (320,400)", ball_x, ball_y);
    end
    checks++;
    if (game_reset !== 1'b0) begin fails++; $display("[TB] FAIL reset_pulse got %b expected 0", game_reset); end
  endtask

  task automatic test_start();
    do_cycle(1, 0, '0, 0);
    checks++;
    if (game_state !== 2'b00 || ball_y !== 10'd400) begin
      fails++; $display("[TB] FAIL start_tick_ignored got state %0d y %0d expected 0 400", game_state, ball_y);
    end
    do_cycle(0, 1, '0, 0);
    checks++;
    if (game_reset !== 1'b1 || game_state !== 2'b01) begin
      fails++; $display("[TB] FAIL start_edge got reset %b state %0d expected 1 1", game_reset, game_state);
    end
    do_cycle(0, 1, '0, 0);
    checks++;
    if (game_reset !== 1'b0) begin fails++; $display("[TB] FAIL start_pulse_width got %b expected 0", game_reset); end
    do_cycle(0, 0, '0, 0);
    run_tick(1);
    checks++;
    if (ball_x !== 10'd322 || ball_y !== 10'd398) begin
      fails++; $display("[TB] FAIL first_tick got (%0d,%0d) expected (322,398)", ball_x, ball_y);
    end
  endtask

  task automatic test_collision();
    int n = 0;
    while (!(m_y == 100 && m_vy < 0) && n < 2000) begin run_tick(1); n++; end
    checks++;
    if (n >= 2000) begin fails++; $display("[TB] FAIL coll_reach got timeout expected y=100 up"); end
    do_cycle(0, 0, '0, 0);
    do_cycle(0, 0, 50'd1 << 5, 0);
    do_cycle(0, 0, '0, 0);
    checks++;
    if (ball_y !== 10'd100) begin fails++; $display("[TB] FAIL coll_no_move got %0d expected 100", ball_y); end
    run_tick(1);
    checks++;
    if (ball_y !== 10'd102) begin fails++; $display("[TB] FAIL coll_bounce got %0d expected 102", ball_y); end
    run_tick(1);
    checks++;
    if (ball_y !== 10'd104) begin fails++; $display("[TB] FAIL coll_latch_clear got %0d expected 104", ball_y); end
  endtask

  task automatic test_walls();
    int n = 0;
    while (!(m_x == 630 && m_vx > 0) && n < 2000) begin run_tick(1); n++; end
    run_tick(1);
    checks++;
    if (ball_x !== 10'd631) begin fails++; $display("[TB] FAIL wall_right got %0d expected 631", ball_x); end
    run_tick(1);
    checks++;
    if (ball_x !== 10'd629) begin fails++; $display("[TB] FAIL wall_right_dir got %0d expected 629", ball_x); end
    n = 0;
    while (!(m_x == 9 && m_vx < 0) && n < 2000) begin run_tick(1); n++; end
    run_tick(1);
    checks++;
    if (ball_x !== 10'd8) begin fails++; $display("[TB] FAIL wall_left got %0d expected 8", ball_x); end
    run_tick(1);
    checks++;
    if (ball_x !== 10'd10) begin fails++; $display("[TB] FAIL wall_left_dir got %0d expected 10", ball_x); end
  endtask

  task automatic test_paddle();
    int n = 0;
    while (!(m_y == 430 && m_vy > 0) && n < 2000) begin run_tick(1); n++; end
    run_tick(1);
    checks++;
    if (ball_y !== 10'd432 || game_state !== 2'b01) begin
      fails++; $display("[TB] FAIL paddle_hit got y %0d state %0d expected 432 1", ball_y, game_state);
    end
    run_tick(1);
    checks++;
    if (ball_y !== 10'd430) begin fails++; $display("[TB] FAIL paddle_dir got %0d expected 430", ball_y); end
  endtask

  task automatic approach_miss(input string tag);
    int n = 0;
    while (!(m_y == 430 && m_vy > 0) && n < 2000) begin run_tick(1); n++; end
    while (!(m_y == 470) && n < 2100) begin run_tick(0); n++; end
    checks++;
    if (n >= 2100 || game_state !== 2'b01) begin
      fails++; $display("[TB] FAIL %s_approach got state %0d y %0d expected 1 470", tag, game_state, ball_y);
    end
  endtask

  task automatic test_miss();
    approach_miss("miss");
    run_tick(0);
    checks++;
    if (game_state !== 2'b11 || ball_y !== 10'd470) begin
      fails++; $display("[TB] FAIL miss_end got state %0d y %0d expected 3 470", game_state, ball_y);
    end
    repeat (3) run_tick(0);
    checks++;
    if (game_state !== 2'b11 || ball_y !== 10'd470 || ball_x !== 10'(m_x)) begin
      fails++; $display("[TB] FAIL miss_frozen got (%0d,%0d) st %0d expected (%0d,470) st 3", ball_x, ball_y, game_state, m_x);
    end
  endtask

  task automatic test_win();
    do_cycle(0, 1, '0, 0);
    checks++;
    if (game_state !== 2'b00 || ball_x !== 10'd320 || ball_y !== 10'd400 || game_reset !== 1'b0) begin
      fails++; $display("[TB] FAIL end_restart got st %0d (%0d,%0d) rst %b expected 0 (320,400) 0", game_state, ball_x, ball_y, game_reset);
    end
    do_cycle(0, 0, '0, 0);
    do_cycle(0, 1, '0, 0);
    do_cycle(0, 0, '0, 0);
    approach_miss("win");
    paddle_x = 10'((m_x < 320) ? m_x + 120 : m_x - 120);
    do_cycle(1, 0, '0, 1);
    checks++;
    if (game_state !== 2'b10) begin fails++; $display("[TB] FAIL win_priority got %0d expected 2", game_state); end
    do_cycle(0, 0, '0, 0);
    run_tick(0);
    checks++;
    if (game_state !== 2'b10 || ball_y !== 10'd470) begin
      fails++; $display("[TB] FAIL win_frozen got st %0d y %0d expected 2 470", game_state, ball_y);
    end
    do_cycle(0, 1, '0, 0);
    checks++;
    if (game_state !== 2'b00 || ball_x !== 10'd320 || ball_y !== 10'd400 || game_reset !== 1'b0) begin
      fails++; $display("[TB] FAIL win_restart got st %0d (%0d,%0d) rst %b expected 0 (320,400) 0", game_state, ball_x, ball_y, game_reset);
    end
    do_cycle(0, 0, '0, 0);
    checks++;
    if (game_reset !== 1'b0) begin fails++; $display("[TB] FAIL win_restart_pulse got %b expected 0", game_reset); end
  endtask

  task automatic test_async_reset();
    do_cycle(0, 1, '0, 0);
    do_cycle(0, 0, '0, 0);
    repeat (5) run_tick(1);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (game_state !== 2'b00 || ball_x !== 10'd320 || ball_y !== 10'd400 || game_reset !== 1'b0) begin
      fails++; $display("[TB] FAIL async_reset_play got st %0d (%0d,%0d) rst %b expected 0 (320,400) 0", game_state, ball_x, ball_y, game_reset);
    end
    @(posedge vga_clk); #1 sys_rst_n = 1'b1;
    model_reset();
    do_cycle(0, 1, '0, 0);
    checks++;
    if (game_reset !== 1'b1) begin fails++; $display("[TB] FAIL async_pre_pulse got %b expected 1", game_reset); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (game_reset !== 1'b0 || game_state !== 2'b00) begin
      fails++; $display("[TB] FAIL async_reset_pulse got rst %b st %0d expected 0 0", game_reset, game_state);
    end
    key_start = 1'b0;
    @(posedge vga_clk); #1 sys_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit key = 0;
    bit fr;
    logic [49:0] coll;
    int p;
    for (int i = 0; i < 5000; i++) begin
      fr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) key = ~key;
      coll = ($urandom_range(0, 15) == 0) ? (50'd1 << $urandom_range(0, 49)) : '0;
      p = m_x + int'($urandom_range(0, 100)) - 50;
      if (p < 0) p = 0;
      paddle_x = 10'(p);
      do_cycle(fr, key, coll, 0);
      checks++;
      if (game_state !== 2'(m_state)) begin
        fails++; $display("[TB] FAIL rand_state cycle %0d got %0d expected %0d", i, game_state, m_state);
      end
      checks++;
      if (ball_x !== 10'(m_x)) begin
        fails++; $display("[TB] FAIL rand_x cycle %0d got %0d expected %0d", i, ball_x, m_x);
      end
      checks++;
      if (ball_y !== 10'(m_y)) begin
        fails++; $display("[TB] FAIL rand_y cycle %0d got %0d expected %0d", i, ball_y, m_y);
      end
      checks++;
      if (game_reset !== m_rst_pulse) begin
        fails++; $display("[TB] FAIL rand_reset cycle %0d got %b expected %b", i, game_reset, m_rst_pulse);
      end
    end
  endtask

  initial begin
    $display("[TB] starting game_ctrl bench");
    test_reset();
    test_start();
    test_collision();
    test_walls();
    test_paddle();
    test_miss();
    test_win();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
